aes128_encrypt_iter: RTL and testbench

Iterative AES-128 forward cipher (FIPS-197), the encryption counterpart to the team's inverse-AES datapath. It processes one round per clock and expands round keys on the fly. It exposes the final round key so the decryptor can start its reverse key schedule without re-expanding. A start/ready/done handshake connects it to the surrounding controller.

---
 rtl/aes_pkg.sv | 83 ++++++++
 rtl/aes_sbox.sv | 39 +++
 rtl/aes128_encrypt_iter.sv | 155 +++++++++++++++
 tb/tb_aes128_encrypt_iter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions: round count, round constants,
//                FSM encoding, GF(2^8) helpers and byte-order helper used
//                by both the forward and inverse datapaths.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // AES-128 round count
  localparam int NR = 10;

  // Controller FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Round constant for key-expansion round rnd (1..10); zero elsewhere
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // LSB position of state byte s[row][col]; byte 0 sits in [127:120],
  // bytes are laid out column-major.
  function automatic int byte_lsb(input int row, input int col);
    return 120 - 32 * col - 8 * row;
  endfunction

  // One MixColumns column; col[31:24] is row 0
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r is rotated left by r positions
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[byte_lsb(rr, c) +: 8] = s[byte_lsb(rr, (c + rr) % 4) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[96 - 32 * c +: 32] = mix_column(s[96 - 32 * c +: 32]);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational forward AES S-box (table lookup).
//  Ports       : a_i [7:0] input byte, y_o [7:0] substituted byte
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  // Entry 0 occupies the top byte of the vector
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Top bit of entry a is 8*(255-a)+7 = {~a, 3'b111}
  logic [10:0] w_idx;
  assign w_idx = {~a_i, 3'b111};
  assign y_o   = SBOX[w_idx -: 8];

endmodule
`default_nettype wire

// File: rtl/aes128_encrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_encrypt_iter
//  Description : Iterative AES-128 encryptor, one round per clock, round
//                keys expanded on the fly. Exposes the round-10 key so the
//                decryptor can run its reverse key schedule directly.
//  Ports       : clk, reset (async, active-high)
//                start    - request, sampled only while ready=1
//                data_in  - plaintext, [127:120] = byte 0, column-major
//                key_in   - cipher key, same byte order
//                ready    - idle, start will be accepted
//                done     - one-cycle pulse, data_out/last_key valid
//                data_out - ciphertext, held until next completion
//                last_key - round-10 key, held with data_out
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_encrypt_iter #(
  parameter int NR = aes_pkg::NR  // only 10 is supported
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic         done,
  output logic [127:0] data_out,
  output logic [127:0] last_key
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_RND = 4'(NR);

  logic [0:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;
  logic [127:0] dout_q, dout_d;
  logic [127:0] lkey_q, lkey_d;

  // ---------------------------------------------------------------- datapath
  logic [127:0] w_sb;
  logic [31:0]  w_rot, w_subw;
  logic [31:0]  w_nk0, w_nk1, w_nk2, w_nk3;
  logic [127:0] w_nk, w_sr, w_mc;

  for (genvar gi = 0; gi < 16; gi++) begin : g_subbytes
    aes_sbox u_sbox (
      .a_i (state_q[127 - 8 * gi -: 8]),
      .y_o (w_sb[127 - 8 * gi -: 8])
    );
  end

  // RotWord of w3 feeds SubWord
  assign w_rot = {key_q[23:0], key_q[31:24]};

  for (genvar gk = 0; gk < 4; gk++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (w_rot[31 - 8 * gk -: 8]),
      .y_o (w_subw[31 - 8 * gk -: 8])
    );
  end

  assign w_nk0 = key_q[127:96] ^ w_subw ^ {rcon(rnd_q), 24'h0};
  assign w_nk1 = key_q[95:64]  ^ w_nk0;
  assign w_nk2 = key_q[63:32]  ^ w_nk1;
  assign w_nk3 = key_q[31:0]   ^ w_nk2;
  assign w_nk  = {w_nk0, w_nk1, w_nk2, w_nk3};

  assign w_sr  = shift_rows(w_sb);
  assign w_mc  = mix_columns(w_sr);

  // ------------------------------------------------------- FSM: state reg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // ------------------------------------------------------- FSM: next state
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: if (start) fsm_d = ST_RUN;
      ST_RUN:  if (rnd_q == LAST_RND) fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------ FSM: outputs/datapath
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    ready_d = ready_q;
    done_d  = 1'b0;  // pulse: always dropped unless the last round fires
    dout_d  = dout_q;
    lkey_d  = lkey_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = data_in ^ key_in;
          key_d   = key_in;
          rnd_d   = 4'd1;
          ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (rnd_q == LAST_RND) begin
          // Final round omits MixColumns
          dout_d  = w_sr ^ w_nk;
          lkey_d  = w_nk;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          state_d = w_mc ^ w_nk;
          key_d   = w_nk;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      dout_q  <= '0;
      lkey_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      lkey_q  <= lkey_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign data_out = dout_q;
  assign last_key = lkey_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_encrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_encrypt_iter
//  Description : Self-checking bench for aes128_encrypt_iter using known
//                AES-128 vectors plus handshake / reset corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] data_in, key_in;
  logic         ready, done;
  logic [127:0] data_out, last_key;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes128_encrypt_iter #(.NR(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .key_in   (key_in),
    .ready    (ready),
    .done     (done),
    .data_out (data_out),
    .last_key (last_key)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] lk;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts. Returns at the
  // negedge after the accepting edge, with inputs scrambled.
  task automatic launch(input logic [127:0] k, input logic [127:0] p);
    start   = 1'b1;
    key_in  = k;
    data_in = p;
    @(negedge clk);
    start   = 1'b0;
    key_in  = {$urandom, $urandom, $urandom, $urandom};
    data_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Cycles from the accepting edge until done is observed (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int     lat, lat2, ndone, dlat;
    bit     hold_bad;

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[2] = '{128'h0, 128'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    reset = 1'b1; start = 1'b0; data_in = '0; key_in = '0;
    #1;
    chk("reset data_out", data_out, 128'h0);
    chk("reset last_key", last_key, 128'h0);
    chk("reset ready", 128'(ready), 128'd1);
    chk("reset done", 128'(done), 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ---- table-driven vectors
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("v%0d ready before start", i), 128'(ready), 128'd1);
      launch(vecs[i].key, vecs[i].pt);
      wait_done(lat);
      chk($sformatf("v%0d latency", i), 128'(lat), 128'd10);
      chk($sformatf("v%0d data_out", i), data_out, vecs[i].ct);
      chk($sformatf("v%0d last_key", i), last_key, vecs[i].lk);
      @(negedge clk);
      chk($sformatf("v%0d done width", i), 128'(done), 128'd0);
    end

    // ---- back-to-back: start in the done cycle
    launch(vecs[0].key, vecs[0].pt);
    wait_done(lat);
    chk("b2b first latency", 128'(lat), 128'd10);
    chk("b2b first data_out", data_out, vecs[0].ct);
    chk("b2b first ready in done cycle", 128'(ready), 128'd1);
    launch(vecs[1].key, vecs[1].pt);
    hold_bad = 1'b0;
    lat2 = 0;
    while (!done && lat2 < 40) begin
      if (data_out !== vecs[0].ct) hold_bad = 1'b1;
      @(negedge clk);
      lat2++;
    end
    chk("b2b done spacing", 128'(lat2 + 1), 128'd11);
    chk("b2b data_out held", 128'(hold_bad), 128'd0);
    chk("b2b second data_out", data_out, vecs[1].ct);
    chk("b2b second last_key", last_key, vecs[1].lk);
    @(negedge clk);

    // ---- start pulses while busy are ignored
    launch(vecs[0].key, vecs[0].pt);
    ndone = 0;
    dlat  = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (dlat < 0) dlat = i;
      end
      start = (i == 2 || i == 4 || i == 6);
      if (start) begin
        data_in = vecs[1].pt;
        key_in  = vecs[1].key;
      end
    end
    start = 1'b0;
    chk("busy-start done count", 128'(ndone), 128'd1);
    chk("busy-start latency", 128'(dlat), 128'd10);
    chk("busy-start data_out", data_out, vecs[0].ct);
    chk("busy-start last_key", last_key, vecs[0].lk);

    // ---- reset during round 5
    launch(vecs[0].key, vecs[0].pt);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort data_out", data_out, 128'h0);
    chk("abort last_key", last_key, 128'h0);
    chk("abort ready", 128'(ready), 128'd1);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no done", 128'(ndone), 128'd0);
    chk("abort data_out stays 0", data_out, 128'h0);
    launch(vecs[0].key, vecs[0].pt);
    wait_done(lat);
    chk("post-abort latency", 128'(lat), 128'd10);
    chk("post-abort data_out", data_out, vecs[0].ct);
    chk("post-abort last_key", last_key, vecs[0].lk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
